// File: rtl/msk_aes_key_schedule.sv
// Masked iterative AES-128 key expansion with d-share Boolean masking.
// Shared layout: unmasked bit b carries its shares at [b*d +: d]; unmasked
// byte k occupies bits [8k +: 8], byte 0 being the first key byte.
// Four masked S-boxes (GF inversion as x^254 built from DOM multipliers)
// feed a LATENCY-deep share pipeline and are reused every round.
// Optional feature: define MSK_KS_REFRESH_EN to remask every key load.
module msk_aes_key_schedule #(
  parameter int d       = 2,
  parameter int LATENCY = 4,
  parameter int NROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [128*d-1:0]      sh_key_in,
  input  logic [16*d*(d-1)-1:0] rnd_bus0w,
  input  logic [16*d*(d-1)-1:0] rnd_bus1w,
  input  logic [16*d*(d-1)-1:0] rnd_bus2w,
  input  logic [16*d*(d-1)-1:0] rnd_bus3w,
`ifdef MSK_KS_REFRESH_EN
  input  logic [128*(d-1)-1:0]  rnd_ref,
`endif
  output logic                  busy,
  output logic                  rk_valid,
  output logic [3:0]            rk_index,
  output logic [128*d-1:0]      sh_rk_out
);

  localparam int RB    = 4*d*(d-1);
  localparam int SW    = 8*d;
  localparam int CNT_W = $clog2(LATENCY+1);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  state_t             state_q, state_d;
  logic [128*d-1:0]   key_q, key_d, keySrc, roundKey;
  logic [7:0]         rcon_q, rcon_d;
  logic [3:0]         round_q, round_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rkValid_q, rkValid_d, loadKey;
  logic [4*SW-1:0]    sbComb, sboxOut;
  logic [4*SW-1:0]    sboxPipe_q [LATENCY];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [SW-1:0] sqShares(logic [SW-1:0] x);
    logic [SW-1:0] y;
    for (int s = 0; s < d; s++) y[8*s +: 8] = gmul(x[8*s +: 8], x[8*s +: 8]);
    return y;
  endfunction

  function automatic logic [SW-1:0] domMul(logic [SW-1:0] a, logic [SW-1:0] b, logic [RB-1:0] r);
    logic [SW-1:0] z;
    int p;
    z = '0;
    p = 0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i == j) begin
          z[8*i +: 8] ^= gmul(a[8*i +: 8], b[8*i +: 8]);
        end else if (i < j) begin
          z[8*i +: 8] ^= gmul(a[8*i +: 8], b[8*j +: 8]) ^ r[8*p +: 8];
          z[8*j +: 8] ^= gmul(a[8*j +: 8], b[8*i +: 8]) ^ r[8*p +: 8];
          p++;
        end
      end
    end
    return z;
  endfunction

  function automatic logic [SW-1:0] affineShares(logic [SW-1:0] x);
    logic [SW-1:0] y;
    logic [7:0] b;
    for (int s = 0; s < d; s++) begin
      b = x[8*s +: 8];
      y[8*s +: 8] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    end
    y[7:0] ^= 8'h63;
    return y;
  endfunction

  function automatic logic [SW-1:0] maskedSbox(logic [SW-1:0] x, logic [RB-1:0] r0,
                                               logic [RB-1:0] r1, logic [RB-1:0] r2,
                                               logic [RB-1:0] r3);
    logic [SW-1:0] x2, x3, x12, x14, x15, x240;
    x2   = sqShares(x);
    x3   = domMul(x2, x, r0);
    x12  = sqShares(sqShares(x3));
    x14  = domMul(x12, x2, r1);
    x15  = domMul(x12, x3, r2);
    x240 = sqShares(sqShares(sqShares(sqShares(x15))));
    return affineShares(domMul(x240, x14, r3));
  endfunction

  function automatic logic [127:0] getShare(logic [128*d-1:0] k, int s);
    logic [127:0] v;
    for (int b = 0; b < 128; b++) v[b] = k[b*d + s];
    return v;
  endfunction

  function automatic logic [128*d-1:0] putShare(logic [128*d-1:0] k, int s, logic [127:0] v);
    for (int b = 0; b < 128; b++) k[b*d + s] = v[b];
    return k;
  endfunction

`ifdef MSK_KS_REFRESH_EN
  function automatic logic [128*d-1:0] remask(logic [128*d-1:0] k, logic [128*(d-1)-1:0] r);
    logic acc;
    for (int b = 0; b < 128; b++) begin
      acc = 1'b0;
      for (int s = 1; s < d; s++) begin
        k[b*d + s] ^= r[b*(d-1) + s - 1];
        acc ^= r[b*(d-1) + s - 1];
      end
      k[b*d] ^= acc;
    end
    return k;
  endfunction
`endif

  // Masked S-boxes on bytes 12..15 of the stored key, one per byte
  always_comb begin : sboxComb
    logic [SW-1:0] sbIn;
    sbComb = '0;
    sbIn   = '0;
    for (int j = 0; j < 4; j++) begin
      for (int s = 0; s < d; s++) begin
        for (int k = 0; k < 8; k++) sbIn[8*s + k] = key_q[(8*(12+j) + k)*d + s];
      end
      sbComb[j*SW +: SW] = maskedSbox(sbIn, rnd_bus0w[j*RB +: RB], rnd_bus1w[j*RB +: RB],
                                      rnd_bus2w[j*RB +: RB], rnd_bus3w[j*RB +: RB]);
    end
  end

  // S-box share pipeline; the key is stable for a round so stage LATENCY-1 is valid at cnt=LATENCY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) sboxPipe_q[i] <= '0;
    end else begin
      sboxPipe_q[0] <= sbComb;
      for (int i = 1; i < LATENCY; i++) sboxPipe_q[i] <= sboxPipe_q[i-1];
    end
  end

  assign sboxOut = sboxPipe_q[LATENCY-1];

  // Share-wise next round key: RotWord(SubWord(w3)) into w0, RCON on share 0, then the word chain
  always_comb begin : roundKeyComb
    logic [127:0] v;
    roundKey = '0;
    v        = '0;
    for (int s = 0; s < d; s++) begin
      v = getShare(key_q, s);
      v[7:0]   ^= sboxOut[1*SW + 8*s +: 8];
      v[15:8]  ^= sboxOut[2*SW + 8*s +: 8];
      v[23:16] ^= sboxOut[3*SW + 8*s +: 8];
      v[31:24] ^= sboxOut[8*s +: 8];
      if (s == 0) v[7:0] ^= rcon_q;
      v[63:32]  ^= v[31:0];
      v[95:64]  ^= v[63:32];
      v[127:96] ^= v[95:64];
      roundKey = putShare(roundKey, s, v);
    end
  end

  // Sequencing of rounds: start acceptance, per-round cycle count, RCON and strobe generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    rkValid_d = 1'b0;
    loadKey   = 1'b0;
    keySrc    = key_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          round_d   = '0;
          rcon_d    = 8'h01;
          rkValid_d = 1'b1;
          loadKey   = 1'b1;
          keySrc    = sh_key_in;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(LATENCY)) begin
          cnt_d     = '0;
          round_d   = round_q + 4'd1;
          rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          rkValid_d = 1'b1;
          loadKey   = 1'b1;
          keySrc    = roundKey;
          if (round_q + 4'd1 == 4'(NROUNDS)) state_d = LAST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key register load path, optionally remasked with fresh randomness
  always_comb begin
`ifdef MSK_KS_REFRESH_EN
    key_d = loadKey ? remask(keySrc, rnd_ref) : key_q;
`else
    key_d = loadKey ? keySrc : key_q;
`endif
  end

  // State, counters and shared key register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      rcon_q    <= 8'h01;
      rkValid_q <= 1'b0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      rcon_q    <= rcon_d;
      rkValid_q <= rkValid_d;
      key_q     <= key_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign rk_valid  = rkValid_q;
  assign rk_index  = round_q;
  assign sh_rk_out = key_q;

endmodule
